// File: rtl/vt_pkg.sv
// ---------------------------------------------------------------------------
// vt_pkg
// Shared definitions for the voltage-translator / SRAM read interlock:
//   - sequencer state enumeration
//   - default turn-on / turn-off settle lengths and settle counter width
// ---------------------------------------------------------------------------
package vt_pkg;

   localparam int DEF_ENABLE_CYCLES = 4;   // VT_EN_OUT rise -> VT_RDY rise
   localparam int DEF_SETTLE_CYCLES = 8;   // VT_EN_OUT fall -> leave VT_OFF_WAIT
   localparam int DEF_CNT_W         = 8;   // settle counter width

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      VT_ON_WAIT  = 3'd1,
      VT_ACTIVE   = 3'd2,
      VT_OFF_WAIT = 3'd3,
      SRAM_GRANT  = 3'd4
   } vt_state_t;

endpackage

// File: rtl/vt_settle_timer.sv
// ---------------------------------------------------------------------------
// vt_settle_timer
// Load-and-count-down timer used for both the translator turn-on and
// turn-off settle intervals. The count saturates at zero.
//   CLK       clock
//   RST       synchronous active-high reset (count cleared)
//   LOAD      load LOAD_VAL this cycle
//   LOAD_VAL  value to load
//   ZERO      count is zero and no load is in progress
// ---------------------------------------------------------------------------
module vt_settle_timer
   import vt_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LOAD,
   input  logic [CNT_W-1:0] LOAD_VAL,
   output logic             ZERO
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (LOAD) begin
         cnt_next = LOAD_VAL;
      end else if (cnt_reg != '0) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // A load in flight masks a stale zero so the caller never sees an
   // expiry in the same cycle it restarts the interval.
   assign ZERO = (cnt_reg == '0) && !LOAD;

endmodule

// File: rtl/vt_sram_interlock.sv
// ---------------------------------------------------------------------------
// vt_sram_interlock
// Sequencer owning the voltage-translator enable request and the SRAM read
// grant. Translators are always off and settled before a read is granted,
// and never enabled while a read is granted. All outputs are registered
// decodes of the next state.
//   CLK           clock
//   RST           synchronous active-high reset
//   VT_REQ        level: client requests translators enabled
//   VT_RDY        translators enabled and settled
//   SRAM_RD_REQ   level: SRAM reader requests access
//   SRAM_RD_GNT   read granted; translators guaranteed off
//   SRAM_RD_DONE  single-cycle pulse: read finished
//   VT_EN_OUT     to translator controller EN_IN
//   BUSY          any state other than IDLE
//   ERR           sticky protocol violation
// ---------------------------------------------------------------------------
module vt_sram_interlock
   import vt_pkg::*;
#(
   parameter int ENABLE_CYCLES = DEF_ENABLE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic CLK,
   input  logic RST,
   input  logic VT_REQ,
   output logic VT_RDY,
   input  logic SRAM_RD_REQ,
   output logic SRAM_RD_GNT,
   input  logic SRAM_RD_DONE,
   output logic VT_EN_OUT,
   output logic BUSY,
   output logic ERR
);

   localparam logic [CNT_W-1:0] ENABLE_LOAD = CNT_W'(ENABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   vt_state_t        state_reg, state_next;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             zero;

   logic vt_en_reg,    vt_en_next;
   logic vt_rdy_reg,   vt_rdy_next;
   logic gnt_reg,      gnt_next;
   logic busy_reg,     busy_next;
   logic err_reg,      err_next;
   logic gnt_first_reg, gnt_first_next;   // high during the first grant cycle

   vt_settle_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .LOAD     (load),
      .LOAD_VAL (load_val),
      .ZERO     (zero)
   );

   // Timer load is decoded without looking at ZERO so that the ZERO -> next
   // state path never loops back through LOAD.
   always_comb begin
      load     = 1'b0;
      load_val = SETTLE_LOAD;
      case (state_reg)
         IDLE: begin
            if (!SRAM_RD_REQ && VT_REQ) begin
               load     = 1'b1;
               load_val = ENABLE_LOAD;
            end
         end
         VT_ON_WAIT, VT_ACTIVE: begin
            if (!VT_REQ || SRAM_RD_REQ) begin
               load = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            // Read wins when both requests arrive together.
            if (SRAM_RD_REQ) begin
               state_next = SRAM_GRANT;
            end else if (VT_REQ) begin
               state_next = VT_ON_WAIT;
            end
         end
         VT_ON_WAIT: begin
            if (!VT_REQ || SRAM_RD_REQ) begin
               state_next = VT_OFF_WAIT;
            end else if (zero) begin
               state_next = VT_ACTIVE;
            end
         end
         VT_ACTIVE: begin
            if (!VT_REQ || SRAM_RD_REQ) begin
               state_next = VT_OFF_WAIT;
            end
         end
         VT_OFF_WAIT: begin
            // Requests are ignored until the turn-off settle has elapsed;
            // IDLE then re-arbitrates.
            if (zero) begin
               state_next = IDLE;
            end
         end
         SRAM_GRANT: begin
            if (SRAM_RD_DONE || !SRAM_RD_REQ) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      vt_en_next     = (state_next == VT_ON_WAIT) || (state_next == VT_ACTIVE);
      vt_rdy_next    = (state_next == VT_ACTIVE);
      gnt_next       = (state_next == SRAM_GRANT);
      busy_next      = (state_next != IDLE);
      gnt_first_next = gnt_next && (state_reg != SRAM_GRANT);

      // A done outside a grant, or in the very first grant cycle (before the
      // reader could have seen the grant), is a protocol violation.
      err_next = err_reg |
                 (SRAM_RD_DONE && ((state_reg != SRAM_GRANT) || gnt_first_reg));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= IDLE;
         vt_en_reg     <= 1'b0;
         vt_rdy_reg    <= 1'b0;
         gnt_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         err_reg       <= 1'b0;
         gnt_first_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         vt_en_reg     <= vt_en_next;
         vt_rdy_reg    <= vt_rdy_next;
         gnt_reg       <= gnt_next;
         busy_reg      <= busy_next;
         err_reg       <= err_next;
         gnt_first_reg <= gnt_first_next;
      end
   end

   assign VT_EN_OUT   = vt_en_reg;
   assign VT_RDY      = vt_rdy_reg;
   assign SRAM_RD_GNT = gnt_reg;
   assign BUSY        = busy_reg;
   assign ERR         = err_reg;

endmodule

// File: tb/tb_vt_sram_interlock.sv
// ---------------------------------------------------------------------------
// tb_vt_sram_interlock
// Two instances: default parameters (dut0) and ENABLE_CYCLES=1 /
// SETTLE_CYCLES=2 (dut1). Stimulus pushes hand-computed output transitions
// {cycle, {EN,RDY,GNT,BUSY,ERR}} into a per-instance queue; the monitor
// pops one entry each time an instance's output vector changes and also
// checks translator/grant exclusion every cycle.
// ---------------------------------------------------------------------------
module tb_vt_sram_interlock;

   typedef struct {
      int         cyc;
      logic [4:0] vec;
   } exp_t;

   logic       clk;
   logic [1:0] rst, req, rd, done;
   logic [1:0] en, rdy, gnt, busy, err;
   logic [4:0] obs [2];
   logic [4:0] prev [2];

   int   cyc = 0;
   int   base;
   int   n_chk = 0;
   int   n_fail = 0;
   logic mon_en;
   logic finished;
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t e;
   logic [4:0] v;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   vt_sram_interlock u_dut0 (
      .CLK(clk), .RST(rst[0]), .VT_REQ(req[0]), .VT_RDY(rdy[0]),
      .SRAM_RD_REQ(rd[0]), .SRAM_RD_GNT(gnt[0]), .SRAM_RD_DONE(done[0]),
      .VT_EN_OUT(en[0]), .BUSY(busy[0]), .ERR(err[0])
   );

   vt_sram_interlock #(
      .ENABLE_CYCLES(1), .SETTLE_CYCLES(2), .CNT_W(8)
   ) u_dut1 (
      .CLK(clk), .RST(rst[1]), .VT_REQ(req[1]), .VT_RDY(rdy[1]),
      .SRAM_RD_REQ(rd[1]), .SRAM_RD_GNT(gnt[1]), .SRAM_RD_DONE(done[1]),
      .VT_EN_OUT(en[1]), .BUSY(busy[1]), .ERR(err[1])
   );

   assign obs[0] = {en[0], rdy[0], gnt[0], busy[0], err[0]};
   assign obs[1] = {en[1], rdy[1], gnt[1], busy[1], err[1]};

   task automatic tk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expect instance d to present vector vv at edge base+k.
   task automatic push_exp(input int d, input int k, input logic [4:0] vv);
      exp_t x;
      x.cyc = base + k;
      x.vec = vv;
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            v = obs[d];
            n_chk++;
            if (v[4] === 1'b1 && v[2] === 1'b1) begin
               n_fail++;
               $display("FAIL exclusion dut%0d cycle %0d: EN=%b GNT=%b, required not both 1",
                        d, cyc, v[4], v[2]);
            end
            if (v !== prev[d]) begin
               n_chk++;
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  n_fail++;
                  $display("FAIL unexpected_change dut%0d cycle %0d: got %b, required %b (no change)",
                           d, cyc, v, prev[d]);
               end else begin
                  if (d == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  if (e.cyc != cyc || e.vec !== v) begin
                     n_fail++;
                     $display("FAIL transition dut%0d: got %b at cycle %0d, required %b at cycle %0d",
                              d, v, cyc, e.vec, e.cyc);
                  end else begin
                     $display("dut%0d cycle %0d: EN RDY GNT BUSY ERR = %b", d, cyc, v);
                  end
               end
               prev[d] = v;
            end
         end
         if (finished) begin
            n_chk++;
            if (q0.size() != 0) begin
               n_fail++;
               $display("FAIL missing_events dut0: %0d transitions never seen, required 0", q0.size());
            end
            n_chk++;
            if (q1.size() != 0) begin
               n_fail++;
               $display("FAIL missing_events dut1: %0d transitions never seen, required 0", q1.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   // Stimulus
   initial begin
      prev[0]  = 5'h1f;   // impossible vector: first sample always compares
      prev[1]  = 5'h1f;
      rst      = 2'b11;
      req      = 2'b00;
      rd       = 2'b00;
      done     = 2'b00;
      mon_en   = 1'b0;
      finished = 1'b0;

      // Reset state
      tk(3);
      base = cyc;
      push_exp(0, 0, 5'b00000);
      push_exp(1, 0, 5'b00000);
      mon_en = 1'b1;
      rst    = 2'b00;
      tk(2);

      // Turn-on: EN at edge 1, RDY at edge 5
      base = cyc; req[0] = 1'b1;
      push_exp(0, 1, 5'b10010);
      push_exp(0, 5, 5'b11010);
      tk(7);

      // Read from VT_ACTIVE: EN/RDY fall edge 1, IDLE edge 9, GNT edge 10
      base = cyc; rd[0] = 1'b1;
      push_exp(0, 1,  5'b00010);
      push_exp(0, 9,  5'b00000);
      push_exp(0, 10, 5'b00110);
      tk(12);
      base = cyc; rd[0] = 1'b0; req[0] = 1'b0;
      push_exp(0, 1, 5'b00000);
      tk(3);

      // Simultaneous requests: read wins, EN stays 0
      base = cyc; req[0] = 1'b1; rd[0] = 1'b1;
      push_exp(0, 1, 5'b00110);
      tk(3);
      base = cyc; done[0] = 1'b1; rd[0] = 1'b0;
      push_exp(0, 1,  5'b00000);
      push_exp(0, 2,  5'b10010);   // VT_REQ still high
      push_exp(0, 3,  5'b00010);   // dropped immediately: abort
      push_exp(0, 11, 5'b00000);
      tk(1); done[0] = 1'b0;
      tk(1); req[0]  = 1'b0;
      tk(10);

      // Abort during VT_ON_WAIT: RDY never rises, 8-cycle off wait
      base = cyc; req[0] = 1'b1;
      push_exp(0, 1,  5'b10010);
      push_exp(0, 3,  5'b00010);
      push_exp(0, 11, 5'b00000);
      tk(2); req[0] = 1'b0;
      tk(12);

      // Done while IDLE -> sticky ERR
      base = cyc; done[0] = 1'b1;
      push_exp(0, 1, 5'b00001);
      tk(1); done[0] = 1'b0;
      tk(3);
      base = cyc; req[0] = 1'b1;
      push_exp(0, 1, 5'b10011);
      push_exp(0, 5, 5'b11011);
      tk(7);
      // Reset in VT_ACTIVE: everything 0 on the next edge
      base = cyc; rst[0] = 1'b1;
      push_exp(0, 1, 5'b00000);
      tk(1); rst[0] = 1'b0; req[0] = 1'b0;
      tk(3);

      // dut1: ENABLE_CYCLES=1, SETTLE_CYCLES=2
      base = cyc; req[1] = 1'b1;
      push_exp(1, 1, 5'b10010);
      push_exp(1, 2, 5'b11010);
      tk(4);
      base = cyc; rd[1] = 1'b1;
      push_exp(1, 1, 5'b00010);
      push_exp(1, 3, 5'b00000);
      push_exp(1, 4, 5'b00110);    // SETTLE+2
      tk(4);
      // Done in the first grant cycle -> ERR, back to IDLE
      base = cyc; done[1] = 1'b1; rd[1] = 1'b0; req[1] = 1'b0;
      push_exp(1, 1, 5'b00001);
      tk(1); done[1] = 1'b0;
      tk(4);

      finished = 1'b1;
   end

endmodule
